// File: rtl/DmaPackage.sv
// Shared types and constants for the single-transfer DMA timing controller.
package DmaPackage;

  typedef enum logic [2:0] {
    SI = 3'd0,
    S0 = 3'd1,
    S1 = 3'd2,
    S2 = 3'd3,
    S3 = 3'd4,
    S4 = 3'd5
  } dma_state_t;

  localparam int   NUM_CH          = 4;
  localparam logic XFER_MEM_TO_IO  = 1'b0;
  localparam logic XFER_IO_TO_MEM  = 1'b1;

  function automatic logic [NUM_CH-1:0] ch_onehot(input logic [1:0] ch);
    return 4'b0001 << ch;
  endfunction

endpackage

// File: rtl/dma_priority_arb.sv
// Fixed-priority request arbiter: channel 0 highest, channel 3 lowest.
module dma_priority_arb (
  input  logic [3:0] req,
  output logic [1:0] idx,
  output logic       valid
);

  always_comb begin
    valid = |req;
    idx   = 2'd0;
    if (req[0])      idx = 2'd0;
    else if (req[1]) idx = 2'd1;
    else if (req[2]) idx = 2'd2;
    else if (req[3]) idx = 2'd3;
  end

endmodule

// File: rtl/dma_timing_control.sv
// Four-channel single-transfer DMA timing controller (SI..S4 bus cycle).
// All outputs decode from registered state so request inputs never reach commands combinationally.
module dma_timing_control
  import DmaPackage::*;
(
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic [3:0]  DREQ,
  input  logic [3:0]  MASK,
  input  logic [3:0]  XFER_WRITE,
  input  logic        HLDA,
  input  logic        READY,
  input  logic        EOP_IN_N,
  input  logic        PROG_WE,
  input  logic [1:0]  PROG_CH,
  input  logic        PROG_SEL,
  input  logic [15:0] PROG_DATA,
  output logic        IDLE_CYCLE,
  output logic        ACTIVE_CYCLE,
  output logic        HRQ,
  output logic [3:0]  DACK,
  output logic        aen,
  output logic        adstb,
  output logic        ior,
  output logic        iow,
  output logic        memr,
  output logic        memw,
  output logic        eop,
  output logic [15:0] ADDR_OUT,
  output logic [3:0]  TC_PULSE
);

  dma_state_t  state_reg, state_next;
  logic [1:0]  ch_reg, ch_next;
  logic        write_reg, write_next;
  logic        ext_eop_reg, ext_eop_next;
  logic [15:0] addr_reg  [NUM_CH];
  logic [15:0] addr_next [NUM_CH];
  logic [15:0] count_reg  [NUM_CH];
  logic [15:0] count_next [NUM_CH];

  logic [1:0]  grant_idx;
  logic        grant_valid;
  logic [3:0]  ch_sel;
  logic        xfer_phase;
  logic        count_zero;

  dma_priority_arb u_arb (
    .req   (DREQ & ~MASK),
    .idx   (grant_idx),
    .valid (grant_valid)
  );

  // Per-channel register update: programming only in SI, post-increment/decrement in S4.
  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic sel_prog;
      logic sel_xfer;
      assign sel_prog = (state_reg == SI) && PROG_WE && (PROG_CH == 2'(gi));
      assign sel_xfer = (state_reg == S4) && (ch_reg == 2'(gi));
      assign addr_next[gi]  = (sel_prog && !PROG_SEL) ? PROG_DATA :
                              sel_xfer ? addr_reg[gi] + 16'd1 : addr_reg[gi];
      assign count_next[gi] = (sel_prog && PROG_SEL) ? PROG_DATA :
                              sel_xfer ? count_reg[gi] - 16'd1 : count_reg[gi];
    end
  endgenerate

  always_comb begin
    state_next   = state_reg;
    ch_next      = ch_reg;
    write_next   = write_reg;
    ext_eop_next = ext_eop_reg;
    case (state_reg)
      SI: begin
        ext_eop_next = 1'b0;
        if (grant_valid) begin
          state_next = S0;
          ch_next    = grant_idx;
          write_next = XFER_WRITE[grant_idx];
        end
      end
      S0: if (HLDA) state_next = S1;
      S1: state_next = HLDA ? S2 : SI;
      S2, S3: begin
        if (!HLDA) begin
          state_next = SI;
        end else if (!EOP_IN_N) begin
          state_next   = S4;
          ext_eop_next = 1'b1;
        end else if (state_reg == S2 || READY) begin
          state_next = (state_reg == S2) ? S3 : S4;
        end
      end
      S4:      state_next = SI;
      default: state_next = SI;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_reg   <= SI;
      ch_reg      <= 2'd0;
      write_reg   <= XFER_MEM_TO_IO;
      ext_eop_reg <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        addr_reg[i]  <= 16'h0000;
        count_reg[i] <= 16'h0000;
      end
    end else begin
      state_reg   <= state_next;
      ch_reg      <= ch_next;
      write_reg   <= write_next;
      ext_eop_reg <= ext_eop_next;
      for (int i = 0; i < NUM_CH; i++) begin
        addr_reg[i]  <= addr_next[i];
        count_reg[i] <= count_next[i];
      end
    end
  end

  // Terminal count is detected on the pre-decrement value (0000 -> FFFF).
  assign ch_sel     = ch_onehot(ch_reg);
  assign xfer_phase = (state_reg == S2) || (state_reg == S3);
  assign count_zero = (count_reg[ch_reg] == 16'h0000);

  always_comb begin
    IDLE_CYCLE   = (state_reg == SI) || (state_reg == S0);
    ACTIVE_CYCLE = !IDLE_CYCLE;
    HRQ          = (state_reg != SI);
    aen          = ACTIVE_CYCLE;
    adstb        = (state_reg == S1);
    DACK         = xfer_phase ? ch_sel : 4'b0000;
    memr         = !(xfer_phase && write_reg == XFER_MEM_TO_IO);
    ior          = !(xfer_phase && write_reg == XFER_IO_TO_MEM);
    iow          = !(state_reg == S3 && write_reg == XFER_MEM_TO_IO);
    memw         = !(state_reg == S3 && write_reg == XFER_IO_TO_MEM);
    eop          = !(state_reg == S4 && count_zero);
    TC_PULSE     = (state_reg == S4 && (count_zero || ext_eop_reg)) ? ch_sel : 4'b0000;
    ADDR_OUT     = addr_reg[ch_reg];
  end

endmodule
